restoring_div: RTL and testbench

Sequential unsigned restoring divider, the inverse companion to the Booth multiplier in the same arithmetic library. It accepts a dividend/divisor pair under a level enable and produces one quotient bit per clock. It presents quotient and remainder with a done flag, using the same enable/done handshake as the multiplier so both blocks can share one controller and one bench style.

---
 rtl/restoring_div.sv | 134 +++++++++++++
 tb/tb_restoring_div.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/restoring_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// held in output flops, level enable / done handshake shared with the multiplier.
module restoring_div #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i_div,
    input  logic                  rstn_i_div,
    input  logic                  en_i_div,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  div_done_o,
    output logic                  div_by_zero_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    quotient_q, quotient_d;
    logic [W-1:0]    remainder_q, remainder_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    // One restoring step: the partial remainder always stays below the divisor,
    // so W bits hold it and only the shifted trial needs the extra bit.
    logic [W:0]      rem_sh;
    logic [W:0]      trial;
    logic [W-1:0]    rem_nx;
    logic [W-1:0]    quo_nx;

    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        trial  = rem_sh - {1'b0, div_q};
        rem_nx = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        quo_nx = {quo_q[W-2:0], ~trial[W]};
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (en_i_div) begin
                    div_d = B;
                    if (B != '0) begin
                        rem_d   = '0;
                        quo_d   = A;
                        cnt_d   = CW'(W);
                        state_d = CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = A;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quotient_d  = quo_nx;
                    remainder_d = rem_nx;
                    done_d      = 1'b1;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!en_i_div) begin
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i_div or negedge rstn_i_div) begin
        if (!rstn_i_div) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_done_o    = done_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_div.sv
// Directed and random checks of restoring_div at 8- and 16-bit widths.
module tb_restoring_div;

    logic        clk;
    logic        rst_n;
    logic        en8, en16;
    logic [7:0]  a8, b8, q8, r8;
    logic [15:0] a16, b16, q16, r16;
    logic        done8, dbz8, done16, dbz16;

    int n_checks = 0;
    int n_err    = 0;

    restoring_div #(.DATA_WIDTH(8)) u_div8 (
        .clk_i_div    (clk),
        .rstn_i_div   (rst_n),
        .en_i_div     (en8),
        .A            (a8),
        .B            (b8),
        .quotient_o   (q8),
        .remainder_o  (r8),
        .div_done_o   (done8),
        .div_by_zero_o(dbz8)
    );

    restoring_div #(.DATA_WIDTH(16)) u_div16 (
        .clk_i_div    (clk),
        .rstn_i_div   (rst_n),
        .en_i_div     (en16),
        .A            (a16),
        .B            (b16),
        .quotient_o   (q16),
        .remainder_o  (r16),
        .div_done_o   (done16),
        .div_by_zero_o(dbz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count negedges until done rises (bounded); n = 1 means done right after accept edge.
    task automatic wait_done(input bit wide, input int start, output int n);
        logic dn;
        n  = start;
        dn = wide ? done16 : done8;
        while (!dn && n < 60) begin
            @(negedge clk);
            n++;
            dn = wide ? done16 : done8;
        end
    endtask

    task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input bit edbz,
                          input string tag);
        int n;
        @(negedge clk);
        if (wide) begin a16 = a; b16 = b; en16 = 1'b1; end
        else begin a8 = a[7:0]; b8 = b[7:0]; en8 = 1'b1; end
        @(negedge clk);
        wait_done(wide, 1, n);
        check({tag, " latency"}, 32'(n), 32'((b == 16'd0) ? 1 : (wide ? 17 : 9)));
        check({tag, " quotient"}, 32'(wide ? q16 : {8'd0, q8}), 32'(eq));
        check({tag, " remainder"}, 32'(wide ? r16 : {8'd0, r8}), 32'(er));
        check({tag, " dbz"}, 32'(wide ? dbz16 : dbz8), 32'(edbz));
        if (wide) en16 = 1'b0; else en8 = 1'b0;
        @(negedge clk);
        check({tag, " done clear"}, 32'(wide ? done16 : done8), 32'd0);
    endtask

    task automatic run_rand(input bit wide);
        logic [15:0] a, b, eq, er;
        a = wide ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
        b = wide ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) b = 16'd0;
        if (b == 16'd0) begin
            eq = wide ? 16'hFFFF : 16'h00FF;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        run_op(wide, a, b, eq, er, b == 16'd0, wide ? "rand16" : "rand8");
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        en8 = 1'b1; a8 = 8'd15; b8 = 8'd4;
        en16 = 1'b0; a16 = 16'd0; b16 = 16'd0;

        // Reset held with enable high: everything stays zero
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst q", 32'(q8), 32'd0);
            check("rst r", 32'(r8), 32'd0);
            check("rst done", 32'(done8), 32'd0);
            check("rst dbz", 32'(dbz8), 32'd0);
            check("rst done16", 32'(done16), 32'd0);
        end
        en8 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after rst", 32'(done8), 32'd0);

        run_op(1'b0, 16'd15, 16'd4, 16'd3, 16'd3, 1'b0, "15/4");
        run_op(1'b0, 16'd255, 16'd1, 16'd255, 16'd0, 1'b0, "255/1");
        run_op(1'b0, 16'd0, 16'd255, 16'd0, 16'd0, 1'b0, "0/255");
        run_op(1'b0, 16'd254, 16'd255, 16'd0, 16'd254, 1'b0, "254/255");
        run_op(1'b0, 16'd255, 16'd255, 16'd1, 16'd0, 1'b0, "255/255");
        run_op(1'b0, 16'd200, 16'd7, 16'd28, 16'd4, 1'b0, "200/7");
        run_op(1'b0, 16'd255, 16'd0, 16'd255, 16'd255, 1'b1, "255/0");
        run_op(1'b0, 16'd9, 16'd0, 16'd255, 16'd9, 1'b1, "9/0");

        // Enable held across DONE: no restart
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd6; en8 = 1'b1;
        @(negedge clk);
        wait_done(1'b0, 1, n);
        check("hold latency", 32'(n), 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold done", 32'(done8), 32'd1);
            check("hold q", 32'(q8), 32'd8);
            check("hold r", 32'(r8), 32'd2);
        end
        en8 = 1'b0;
        @(negedge clk);
        check("hold release", 32'(done8), 32'd0);
        run_op(1'b0, 16'd7, 16'd9, 16'd0, 16'd7, 1'b0, "7/9");

        // Operand change mid-CALC is ignored; outputs hold previous result meanwhile
        @(negedge clk);
        a8 = 8'd77; b8 = 8'd5; en8 = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        a8 = 8'd13; b8 = 8'd2;
        check("calc holds q", 32'(q8), 32'd0);
        check("calc holds r", 32'(r8), 32'd7);
        wait_done(1'b0, 3, n);
        check("chg latency", 32'(n), 32'd9);
        check("chg q", 32'(q8), 32'd15);
        check("chg r", 32'(r8), 32'd2);
        en8 = 1'b0;
        @(negedge clk);

        // Enable dropped at iteration 3: finishes, single-cycle done
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd7; en8 = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        en8 = 1'b0;
        wait_done(1'b0, 3, n);
        check("drop latency", 32'(n), 32'd9);
        check("drop q", 32'(q8), 32'd28);
        check("drop r", 32'(r8), 32'd4);
        @(negedge clk);
        check("drop pulse", 32'(done8), 32'd0);
        @(negedge clk);
        check("drop idle", 32'(done8), 32'd0);
        check("drop q held", 32'(q8), 32'd28);

        // Reset at iteration 4 clears outputs without a clock
        a8 = 8'd250; b8 = 8'd3; en8 = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst q", 32'(q8), 32'd0);
        check("midrst r", 32'(r8), 32'd0);
        check("midrst done", 32'(done8), 32'd0);
        en8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, "100/10");

        run_op(1'b1, 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, "w65535/1");
        run_op(1'b1, 16'd50000, 16'd333, 16'd150, 16'd50, 1'b0, "w50000/333");
        run_op(1'b1, 16'd1000, 16'd0, 16'hFFFF, 16'd1000, 1'b1, "w1000/0");

        for (int i = 0; i < 1000; i++) run_rand(1'b0);
        for (int i = 0; i < 1000; i++) run_rand(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
